// File: rtl/udp_cmd_rx_pkg.sv
// udp_cmd_rx_pkg
//   Shared constants for the DM9000A UDP command receive path: port numbers,
//   frame offsets, sync/trailer bytes and result codes. The ACK writer uses the
//   same layout: UDP header at byte 34, payload 55 AA EB 90, 6 x control word, AA 55.
//   Also holds the parser state type and the error-priority helper.
package udp_cmd_rx_pkg;

    localparam logic [15:0] PC_PORT          = 16'h1F90;
    localparam logic [15:0] DM9000A_PORT     = 16'h1F91;

    localparam logic [9:0]  PROTO_OFFSET_DEF = 10'd23;
    localparam logic [9:0]  UDP_OFFSET_DEF   = 10'd34;
    localparam logic [15:0] UDP_LEN_DEF      = 16'd26;

    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
    localparam logic [7:0]  SYNC0            = 8'h55;
    localparam logic [7:0]  SYNC1            = 8'hAA;
    localparam logic [7:0]  SYNC2            = 8'hEB;
    localparam logic [7:0]  SYNC3            = 8'h90;
    localparam logic [7:0]  TRAIL0           = 8'hAA;
    localparam logic [7:0]  TRAIL1           = 8'h55;

    localparam logic [2:0]  ERR_NONE         = 3'd0;
    localparam logic [2:0]  ERR_PROTO        = 3'd1;
    localparam logic [2:0]  ERR_PORT         = 3'd2;
    localparam logic [2:0]  ERR_LEN          = 3'd3;
    localparam logic [2:0]  ERR_FRAME        = 3'd4;
    localparam logic [2:0]  ERR_COPY         = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rx_state_e;

    // Lowest non-zero code wins; zero means "no error".
    function automatic logic [2:0] err_merge(input logic [2:0] a, input logic [2:0] b);
        if (a == ERR_NONE)
            return b;
        if (b == ERR_NONE)
            return a;
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/udp_cmd_rx_chk.sv
// udp_cmd_chk
//   Sticky byte-compare and error-priority unit. Follows the RX RAM read port
//   (address + enable), lines each returned byte up with its address and checks
//   it against the fixed command-frame layout. Only the source port, the first
//   control-word copy and the running 3-bit error code are stored.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        restart: drop stored state before a new parse
//   rd_en        RAM read enable as issued this cycle
//   rd_addr      RAM read address as issued this cycle
//   rd_data      RAM read data (belongs to the address issued two edges ago)
//   port         captured UDP source port
//   first_word   captured first control-word copy
//   err          error code including the byte currently on rd_data
module udp_cmd_chk
    import udp_cmd_rx_pkg::*;
#(
    parameter logic [9:0]  PROTO_OFFSET = PROTO_OFFSET_DEF,
    parameter logic [9:0]  UDP_OFFSET   = UDP_OFFSET_DEF,
    parameter logic [15:0] UDP_LEN      = UDP_LEN_DEF,
    parameter logic [15:0] LOCAL_PORT   = DM9000A_PORT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        rd_en,
    input  logic [9:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic [15:0] port,
    output logic [15:0] first_word,
    output logic [2:0]  err
);

    // The RAM latches the address one edge after we issue it, so the byte on
    // rd_data belongs to the address issued one cycle earlier than byte_addr's
    // register update -- i.e. byte_addr below.
    logic       byte_vld;
    logic [9:0] byte_addr;
    logic [9:0] rel;
    logic [2:0] err_q;
    logic [2:0] byte_err;

    assign rel = byte_addr - UDP_OFFSET;

    always_comb begin
        byte_err = ERR_NONE;
        if (byte_vld) begin
            if (byte_addr == PROTO_OFFSET) begin
                if (rd_data != IP_PROTO_UDP) byte_err = ERR_PROTO;
            end else begin
                case (rel)
                    10'd2:  if (rd_data != LOCAL_PORT[15:8]) byte_err = ERR_PORT;
                    10'd3:  if (rd_data != LOCAL_PORT[7:0])  byte_err = ERR_PORT;
                    10'd4:  if (rd_data != UDP_LEN[15:8])    byte_err = ERR_LEN;
                    10'd5:  if (rd_data != UDP_LEN[7:0])     byte_err = ERR_LEN;
                    10'd8:  if (rd_data != SYNC0)            byte_err = ERR_FRAME;
                    10'd9:  if (rd_data != SYNC1)            byte_err = ERR_FRAME;
                    10'd10: if (rd_data != SYNC2)            byte_err = ERR_FRAME;
                    10'd11: if (rd_data != SYNC3)            byte_err = ERR_FRAME;
                    10'd24: if (rd_data != TRAIL0)           byte_err = ERR_FRAME;
                    10'd25: if (rd_data != TRAIL1)           byte_err = ERR_FRAME;
                    default: begin
                        // Copies 2..6: even offsets are high bytes, odd are low.
                        if (rel >= 10'd14 && rel <= 10'd23) begin
                            if (rd_data != (rel[0] ? first_word[7:0] : first_word[15:8]))
                                byte_err = ERR_COPY;
                        end
                    end
                endcase
            end
        end
    end

    assign err = err_merge(err_q, byte_err);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            byte_vld   <= 1'b0;
            byte_addr  <= '0;
            err_q      <= ERR_NONE;
            port       <= '0;
            first_word <= '0;
        end else begin
            byte_vld  <= rd_en;
            byte_addr <= rd_addr;
            err_q     <= err;
            if (byte_vld) begin
                case (rel)
                    10'd0:   port[15:8]       <= rd_data;
                    10'd1:   port[7:0]        <= rd_data;
                    10'd12:  first_word[15:8] <= rd_data;
                    10'd13:  first_word[7:0]  <= rd_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/udp_cmd_rx.sv
// udp_cmd_rx
//   Parses one UDP command frame held in the DM9000A RX buffer RAM. Reads the
//   IP protocol byte and the 26-byte UDP datagram back to back, validates it on
//   the fly and, on success, presents the PC source port and control word.
// Ports:
//   iDm9000aClk    clock
//   iRst_n         synchronous active-low reset
//   iRxStart       level: a frame is ready; parse while high
//   q_b            RX RAM read data
//   address_b      RX RAM read address (registered)
//   rden_b         RX RAM read enable (registered)
//   oPort_pc       source port of the last accepted frame
//   oControl_word  control word of the last accepted frame
//   oCmdValid      one-cycle pulse when a frame is accepted
//   oRunEnd        parse finished, held until iRxStart drops
//   oErr           result code while oRunEnd is high (0 = accepted)
module udp_cmd_rx
    import udp_cmd_rx_pkg::*;
#(
    parameter logic [9:0]  PROTO_OFFSET = PROTO_OFFSET_DEF,
    parameter logic [9:0]  UDP_OFFSET   = UDP_OFFSET_DEF,
    parameter logic [15:0] UDP_LEN      = UDP_LEN_DEF,
    parameter logic [15:0] LOCAL_PORT   = DM9000A_PORT
) (
    input  logic        iDm9000aClk,
    input  logic        iRst_n,
    input  logic        iRxStart,
    input  logic [7:0]  q_b,
    output logic [9:0]  address_b,
    output logic        rden_b,
    output logic [15:0] oPort_pc,
    output logic [15:0] oControl_word,
    output logic        oCmdValid,
    output logic        oRunEnd,
    output logic [2:0]  oErr
);

    localparam logic [9:0] LAST_ADDR = UDP_OFFSET + UDP_LEN[9:0] - 10'd1;

    rx_state_e   state;
    logic        chk_clear;
    logic [15:0] chk_port;
    logic [15:0] chk_word;
    logic [2:0]  chk_err;

    assign chk_clear = (state == ST_IDLE) && iRxStart;

    udp_cmd_chk #(
        .PROTO_OFFSET (PROTO_OFFSET),
        .UDP_OFFSET   (UDP_OFFSET),
        .UDP_LEN      (UDP_LEN),
        .LOCAL_PORT   (LOCAL_PORT)
    ) u_chk (
        .clk        (iDm9000aClk),
        .rst_n      (iRst_n),
        .clear      (chk_clear),
        .rd_en      (rden_b),
        .rd_addr    (address_b),
        .rd_data    (q_b),
        .port       (chk_port),
        .first_word (chk_word),
        .err        (chk_err)
    );

    always_ff @(posedge iDm9000aClk) begin
        if (!iRst_n) begin
            state         <= ST_IDLE;
            address_b     <= '0;
            rden_b        <= 1'b0;
            oPort_pc      <= '0;
            oControl_word <= '0;
            oCmdValid     <= 1'b0;
            oRunEnd       <= 1'b0;
            oErr          <= ERR_NONE;
        end else begin
            oCmdValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iRxStart) begin
                        address_b <= PROTO_OFFSET;
                        rden_b    <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Protocol byte first, then jump to the UDP header and
                    // stream the datagram contiguously.
                    if (address_b == LAST_ADDR) begin
                        address_b <= '0;
                        rden_b    <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (address_b == PROTO_OFFSET) begin
                        address_b <= UDP_OFFSET;
                    end else begin
                        address_b <= address_b + 10'd1;
                    end
                end
                ST_DRAIN: begin
                    // The last trailer byte is on q_b now; chk_err already
                    // includes it.
                    oRunEnd <= 1'b1;
                    oErr    <= chk_err;
                    if (chk_err == ERR_NONE) begin
                        oPort_pc      <= chk_port;
                        oControl_word <= chk_word;
                        oCmdValid     <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!iRxStart) begin
                        oRunEnd <= 1'b0;
                        oErr    <= ERR_NONE;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_cmd_rx.sv
// tb_udp_cmd_rx
//   Self-checking bench for udp_cmd_rx: an RX RAM model with one-cycle read
//   latency, directed frames from the test plan, then randomized frames with
//   random field corruption, all checked against a frame-level reference model.
module tb_udp_cmd_rx;
    import udp_cmd_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_start = 1'b0;
    logic [7:0]  q_b = 8'h00;
    logic [9:0]  address_b;
    logic        rden_b;
    logic [15:0] port_pc;
    logic [15:0] cword;
    logic        cmd_valid;
    logic        run_end;
    logic [2:0]  err;

    logic [7:0]  mem [0:1023];
    int          n_chk = 0;
    int          n_err = 0;
    int          pulse_cnt = 0;
    logic [15:0] exp_port = 16'h0;
    logic [15:0] exp_cw = 16'h0;

    always #5 clk = ~clk;

    udp_cmd_rx dut (
        .iDm9000aClk   (clk),
        .iRst_n        (rst_n),
        .iRxStart      (rx_start),
        .q_b           (q_b),
        .address_b     (address_b),
        .rden_b        (rden_b),
        .oPort_pc      (port_pc),
        .oControl_word (cword),
        .oCmdValid     (cmd_valid),
        .oRunEnd       (run_end),
        .oErr          (err)
    );

    // RAM: address latched at an edge, data available after that edge.
    always @(posedge clk) if (rden_b) q_b <= mem[address_b];

    always @(negedge clk) if (cmd_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: frame-level rules, first failing rule wins.
    function automatic logic [2:0] ref_err();
        logic [15:0] w0;
        w0 = {mem[46], mem[47]};
        if (mem[23] != 8'h11) return 3'd1;
        if ({mem[36], mem[37]} != DM9000A_PORT) return 3'd2;
        if ({mem[38], mem[39]} != 16'd26) return 3'd3;
        if ({mem[42], mem[43], mem[44], mem[45]} != 32'h55AAEB90 ||
            {mem[58], mem[59]} != 16'hAA55) return 3'd4;
        for (int i = 1; i < 6; i++)
            if ({mem[46 + 2*i], mem[47 + 2*i]} != w0) return 3'd5;
        return 3'd0;
    endfunction

    task automatic build_valid(input logic [15:0] src, input logic [15:0] w);
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[23] = 8'h11;
        {mem[34], mem[35]} = src;
        {mem[36], mem[37]} = DM9000A_PORT;
        {mem[38], mem[39]} = 16'd26;
        {mem[42], mem[43], mem[44], mem[45]} = 32'h55AAEB90;
        for (int i = 0; i < 6; i++) {mem[46 + 2*i], mem[47 + 2*i]} = w;
        {mem[58], mem[59]} = 16'hAA55;
    endtask

    // mode 0: drop start after DONE; 1: drop start mid-parse; 2: hold start 40 cycles after DONE
    task automatic do_frame(input string tag, input int mode);
        logic [2:0] e;
        int lat, p0, bad;
        e = ref_err();
        if (e == 3'd0) begin
            exp_port = {mem[34], mem[35]};
            exp_cw   = {mem[46], mem[47]};
        end
        p0 = pulse_cnt; lat = -1; bad = 0;
        rx_start = 1'b1;
        @(posedge clk); @(negedge clk);
        if (address_b !== 10'd23 || rden_b !== 1'b1) bad++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (mode == 1 && k == 5) rx_start = 1'b0;
            if (k <= 27) begin
                if (address_b !== ((k == 27) ? 10'd0 : 10'(33 + k)) || rden_b !== (k < 27)) bad++;
            end
            if (run_end === 1'b1) begin lat = k; break; end
        end
        chk({tag, " latency"}, lat, 28);
        chk({tag, " err"}, err, e);
        chk({tag, " cmd_valid"}, cmd_valid, e == 3'd0);
        chk({tag, " port"}, port_pc, exp_port);
        chk({tag, " cword"}, cword, exp_cw);
        chk({tag, " addr trace"}, bad, 0);
        if (mode == 1) begin
            @(negedge clk);
            chk({tag, " run_end single"}, run_end, 0);
        end else begin
            bad = 0;
            repeat ((mode == 2) ? 40 : 1) begin
                @(negedge clk);
                if (run_end !== 1'b1 || rden_b !== 1'b0 || cmd_valid !== 1'b0 || err !== e) bad++;
            end
            chk({tag, " done held"}, bad, 0);
            rx_start = 1'b0;
            @(negedge clk); @(negedge clk);
            chk({tag, " release"}, {run_end, err}, 0);
        end
        chk({tag, " pulses"}, pulse_cnt - p0, e == 3'd0);
    endtask

    initial begin
        int r, idx;
        repeat (3) @(negedge clk);
        chk("reset addr/rd", {address_b, rden_b}, 0);
        chk("reset port/cw", {port_pc, cword}, 0);
        chk("reset flags", {cmd_valid, run_end, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        build_valid(16'h1F90, 16'hA5C3);
        do_frame("valid", 0);

        build_valid(16'h1F90, 16'hA5C3);
        mem[23] = 8'h06; mem[37] = mem[37] ^ 8'h01;
        do_frame("proto+dst", 0);

        build_valid(16'h1F90, 16'hA5C3);
        {mem[52], mem[53]} = 16'hA5C2;
        do_frame("copy4", 0);

        build_valid(16'h1F90, 16'hA5C3);
        {mem[58], mem[59]} = 16'h55AA;
        do_frame("trailer", 0);

        build_valid(16'h1F90, 16'hA5C3);
        {mem[38], mem[39]} = 16'h001B;
        do_frame("len", 0);

        // Reset in the middle of a parse.
        build_valid(16'h1234, 16'h5678);
        rx_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 15; k++) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midreset addr/rd", {address_b, rden_b}, 0);
        chk("midreset port/cw", {port_pc, cword}, 0);
        chk("midreset flags", {cmd_valid, run_end, err}, 0);
        exp_port = 16'h0; exp_cw = 16'h0;
        rst_n = 1'b1; rx_start = 1'b0;
        @(negedge clk); @(negedge clk);
        do_frame("after reset", 0);

        build_valid(16'h1F90, 16'hBEEF);
        do_frame("hold", 2);
        build_valid(16'h1F90, 16'h0001);
        do_frame("reparse", 0);

        build_valid(16'h1F90, 16'h7E7E);
        do_frame("early drop", 1);

        for (int n = 0; n < 30; n++) begin
            build_valid(16'($urandom), 16'($urandom));
            repeat (1 + (($urandom_range(0, 3) == 0) ? 1 : 0)) begin
                r = $urandom_range(0, 7);
                case (r)
                    0: mem[23] = 8'($urandom);
                    1: mem[36 + $urandom_range(0, 1)] = 8'($urandom);
                    2: mem[38 + $urandom_range(0, 1)] = 8'($urandom);
                    3: mem[42 + $urandom_range(0, 3)] = 8'($urandom);
                    4: begin
                        idx = 46 + $urandom_range(0, 11);
                        mem[idx] = mem[idx] ^ 8'(1 << $urandom_range(0, 7));
                    end
                    5: mem[58 + $urandom_range(0, 1)] = 8'($urandom);
                    default: ;
                endcase
            end
            do_frame($sformatf("rand%0d", n), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/udp_cmd_rx.md
Name: udp_cmd_rx

Overview:
- Parses one received UDP command frame already stored in the DM9000A RX buffer RAM, reading it byte by byte over the RAM's read port.
- Validates the fixed 26-byte command datagram: IP protocol, local port, UDP length, sync header, trailer and six redundant control-word copies.
- On success, presents the PC port and the 16-bit control word to the command/ACK logic.
- It is the receive-side counterpart of the UDP ACK writer and uses the same frame layout: UDP header at byte 34, payload 55 AA EB 90, 6 x control word, AA 55.

Parameters:
- PROTO_OFFSET, 10'd23, byte address of the IP protocol field.
- UDP_OFFSET, 10'd34, byte address of the first UDP header byte.
- UDP_LEN, 16'd26, required UDP length field (8-byte header + 18-byte payload).
- LOCAL_PORT, `DM9000A_Port, required UDP destination port.

Ports:
- iDm9000aClk  in  1  single clock for the whole block.
- iRst_n  in  1  synchronous active-low reset.
- iRxStart  in  1  level: a complete frame is in the RX RAM; parse while high.
- q_b  in  8  RX RAM read data, valid exactly 1 cycle after address_b.
- address_b  out  10  RX RAM read address (registered).
- rden_b  out  1  RX RAM read enable (registered).
- oPort_pc  out  16  UDP source port of the accepted frame.
- oControl_word  out  16  accepted control word.
- oCmdValid  out  1  1-cycle pulse: frame accepted, outputs updated.
- oRunEnd  out  1  parse finished (pass or fail); held until iRxStart low.
- oErr  out  3  result code, valid while oRunEnd=1.

Behaviour:
- Reset (iRst_n=0 at a clock edge): state Idle; address_b=0, rden_b=0, oPort_pc=0, oControl_word=0, oCmdValid=0, oRunEnd=0, oErr=0. Reset mid-parse aborts it; no partial update of oPort_pc or oControl_word.
- States:
  - Idle: wait for iRxStart=1. On that edge: address_b<=PROTO_OFFSET, rden_b<=1, go to READ.
  - READ: each cycle address_b advances through 34..59 (UDP_OFFSET..UDP_OFFSET+UDP_LEN-1), back to back, 27 reads in total. Each q_b byte is captured one cycle after its address. Going to DRAIN sets rden_b<=0 and address_b<=0.
  - DRAIN: sample the byte for address 59, evaluate, go to DONE.
  - DONE: oRunEnd=1 and oErr are registered. If oErr=0: oPort_pc and oControl_word are loaded and oCmdValid pulses for exactly one cycle. Stay in DONE while iRxStart=1; when iRxStart=0, clear oRunEnd and oErr and return to Idle. oPort_pc and oControl_word hold their values.
- Latency: oRunEnd rises on the 28th rising edge after the edge that first sampled iRxStart=1.
- Checks, with oErr codes. When several checks fail, the lowest-numbered code wins.
  - 1: protocol byte at 23 is not 8'h11.
  - 2: dst port (bytes 36,37, big-endian) is not LOCAL_PORT.
  - 3: length field (bytes 38,39) is not UDP_LEN.
  - 4: bytes 42..45 are not 55 AA EB 90, or bytes 58,59 are not AA 55.
  - 5: any of the six control-word copies (bytes 46..57, big-endian pairs) differs from the first copy.
  - 0: pass.
- The UDP checksum (bytes 40,41) is ignored. The src port (bytes 34,35) is captured as oPort_pc.
- Comparisons are done on the fly with sticky error flags; the full frame is not buffered. Storage is limited to the 16-bit port, 16-bit first copy, and 3-bit error.
- iRxStart dropping mid-parse does not abort the parse. The parse completes, DONE is entered, and the block returns to Idle on the next edge, still giving oRunEnd a single-cycle pulse. A new parse needs iRxStart low in Idle, then high again.

Decomposition:
- DM9000A.def holds PC_Port, DM9000A_Port, UDP_OFFSET/PROTO_OFFSET, the sync/trailer byte constants, and the oErr code defines. The ACK writer shares these.
- One sub-module is natural: udp_cmd_chk, the sticky byte-compare/error-priority unit, driven by the byte index and q_b.

Test Plan:
- Valid frame, proto 11, src 0x1F90, dst LOCAL_PORT, len 26, control word 0xA5C3 x6 -> oRunEnd rises 28 edges after start; oErr=0, oPort_pc=0x1F90, oControl_word=0xA5C3, one oCmdValid pulse.
- Same frame with byte 23=0x06 and dst port wrong -> oErr=1, no oCmdValid, oControl_word keeps its previous value.
- Copy 4 = 0xA5C2 -> oErr=5; trailer 55 AA instead of AA 55 -> oErr=4; len 0x001B -> oErr=3.
- Address trace check: address_b sequence 23, 34, 35 ... 59 on consecutive cycles with rden_b=1, then 0/0.
- iRst_n asserted at read 15 -> next edge all outputs 0, state Idle; a following valid frame parses correctly.
- iRxStart held high after DONE -> no second parse; drop then raise -> second parse with control word 0x0001 -> oControl_word=0x0001.
